vlsu_req_dispatcher: RTL and testbench

// Generalised request front-end for the VLSU. Replaces the single in-order instruction queue.
// pe requests are split by isLoad into separate load and store queues of parametrised depth.

---
 rtl/vlsu_pkg.sv | 24 ++
 rtl/vlsu_dispatch_queue.sv | 52 +++++
 rtl/vlsu_req_dispatcher.sv | 129 ++++++++++++
 tb/tb_vlsu_req_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared VLSU dispatch types: request word, age snapshot tag and queue entry.
// Age tags are sized so that in-flight plus queued ops can never alias modulo 2^CntW.
package vlsu_pkg;

  localparam int DefLdQueueDepth = 4;
  localparam int DefStQueueDepth = 4;
  localparam int DefMaxLdOut     = 2;
  localparam int DefMaxStOut     = 2;
  localparam int CntW = $clog2(DefLdQueueDepth + DefStQueueDepth + DefMaxLdOut + DefMaxStOut) + 1;

  typedef struct packed {
    logic        isLoad;
    logic [7:0]  id;
    logic [31:0] addr;
  } vlsu_req_t;

  typedef logic [CntW-1:0] age_tag_t;

  typedef struct packed {
    vlsu_req_t req;
    age_tag_t  tag;
  } dispatch_entry_t;

endpackage

// File: rtl/vlsu_dispatch_queue.sv
// Generic FIFO, head served from registers (no flow-through): push to data_o valid is 1 cycle.
// Push while full and pop while empty are ignored; the caller gates them with full_o/empty_o.
module vlsu_dispatch_queue #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/vlsu_req_dispatcher.sv
// VLSU request front-end: splits requests into load/store queues, orders them by age snapshots,
// caps outstanding ops per side. Enqueue to dispatch valid >= 1 cycle; per-side valid/ready backpressure.
module vlsu_req_dispatcher
  import vlsu_pkg::*;
#(
  parameter int LdQueueDepth = DefLdQueueDepth,
  parameter int StQueueDepth = DefStQueueDepth,
  parameter int MaxLdOut     = DefMaxLdOut,
  parameter int MaxStOut     = DefMaxStOut,
  localparam int LdOutW      = $clog2(MaxLdOut + 1),
  localparam int StOutW      = $clog2(MaxStOut + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  vlsu_req_t         req_i,
  input  logic              core_st_pending_i,
  output logic              ld_req_valid_o,
  input  logic              ld_req_ready_i,
  output vlsu_req_t         ld_req_o,
  output logic              st_req_valid_o,
  input  logic              st_req_ready_i,
  output vlsu_req_t         st_req_o,
  input  logic              ld_done_i,
  input  logic              st_done_i,
  output logic [LdOutW-1:0] ld_outstanding_o,
  output logic [StOutW-1:0] st_outstanding_o,
  output logic              idle_o
);

  localparam logic [LdOutW-1:0] LdOutCap = LdOutW'(MaxLdOut);
  localparam logic [StOutW-1:0] StOutCap = StOutW'(MaxStOut);

  age_tag_t          ld_enq_cnt_q, ld_enq_cnt_d, st_enq_cnt_q, st_enq_cnt_d;
  age_tag_t          ld_done_cnt_q, ld_done_cnt_d, st_done_cnt_q, st_done_cnt_d;
  logic [LdOutW-1:0] ld_out_q, ld_out_d;
  logic [StOutW-1:0] st_out_q, st_out_d;

  dispatch_entry_t ldq_wdata, ldq_head, stq_wdata, stq_head;
  logic            ldq_full, ldq_empty, stq_full, stq_empty;
  logic            ld_push, st_push, ld_fire, st_fire, ld_done_ok, st_done_ok;

  assign req_ready_o = req_i.isLoad ? !ldq_full : !stq_full;
  assign ld_push     = req_valid_i && req_ready_o && req_i.isLoad;
  assign st_push     = req_valid_i && req_ready_o && !req_i.isLoad;

  // Each entry remembers how many opposite-side ops were older than it.
  assign ldq_wdata = '{req: req_i, tag: st_enq_cnt_q};
  assign stq_wdata = '{req: req_i, tag: ld_enq_cnt_q};

  vlsu_dispatch_queue #(.T(dispatch_entry_t), .DEPTH(LdQueueDepth)) u_ldq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ld_push),
    .data_i  (ldq_wdata),
    .pop_i   (ld_fire),
    .data_o  (ldq_head),
    .full_o  (ldq_full),
    .empty_o (ldq_empty)
  );

  vlsu_dispatch_queue #(.T(dispatch_entry_t), .DEPTH(StQueueDepth)) u_stq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (st_push),
    .data_i  (stq_wdata),
    .pop_i   (st_fire),
    .data_o  (stq_head),
    .full_o  (stq_full),
    .empty_o (stq_empty)
  );

  assign ld_req_valid_o = !ldq_empty && (st_done_cnt_q == ldq_head.tag) && !core_st_pending_i
                          && (ld_out_q < LdOutCap);
  assign st_req_valid_o = !stq_empty && (ld_done_cnt_q == stq_head.tag) && (st_out_q < StOutCap);
  assign ld_req_o       = ldq_head.req;
  assign st_req_o       = stq_head.req;
  assign ld_fire        = ld_req_valid_o && ld_req_ready_i;
  assign st_fire        = st_req_valid_o && st_req_ready_i;

  // A done pulse with nothing in flight is dropped so age counts stay consistent.
  assign ld_done_ok = ld_done_i && (ld_out_q != '0);
  assign st_done_ok = st_done_i && (st_out_q != '0);

  always_comb begin
    ld_enq_cnt_d  = ld_enq_cnt_q + age_tag_t'(ld_push);
    st_enq_cnt_d  = st_enq_cnt_q + age_tag_t'(st_push);
    ld_done_cnt_d = ld_done_cnt_q + age_tag_t'(ld_done_ok);
    st_done_cnt_d = st_done_cnt_q + age_tag_t'(st_done_ok);
    ld_out_d      = ld_out_q;
    st_out_d      = st_out_q;
    if (ld_fire && !ld_done_ok)      ld_out_d = ld_out_q + LdOutW'(1);
    else if (!ld_fire && ld_done_ok) ld_out_d = ld_out_q - LdOutW'(1);
    if (st_fire && !st_done_ok)      st_out_d = st_out_q + StOutW'(1);
    else if (!st_fire && st_done_ok) st_out_d = st_out_q - StOutW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_enq_cnt_q  <= '0;
      st_enq_cnt_q  <= '0;
      ld_done_cnt_q <= '0;
      st_done_cnt_q <= '0;
      ld_out_q      <= '0;
      st_out_q      <= '0;
    end else begin
      ld_enq_cnt_q  <= ld_enq_cnt_d;
      st_enq_cnt_q  <= st_enq_cnt_d;
      ld_done_cnt_q <= ld_done_cnt_d;
      st_done_cnt_q <= st_done_cnt_d;
      ld_out_q      <= ld_out_d;
      st_out_q      <= st_out_d;
    end
  end

  assign ld_outstanding_o = ld_out_q;
  assign st_outstanding_o = st_out_q;
  assign idle_o = ldq_empty && stq_empty && (ld_out_q == '0) && (st_out_q == '0);

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(ld_done_i && ld_out_q == '0)) else $warning("ld_done_i with no load outstanding");
      assert (!(st_done_i && st_out_q == '0)) else $warning("st_done_i with no store outstanding");
      assert (ld_out_q <= LdOutCap && st_out_q <= StOutCap) else $error("outstanding count above cap");
    end
  end

endmodule

// File: tb/tb_vlsu_req_dispatcher.sv
// Directed bench for vlsu_req_dispatcher: ordering, caps, backpressure and reset scenarios.
module tb_vlsu_req_dispatcher;
  import vlsu_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i;
  logic      req_valid_i;
  logic      req_ready_o;
  vlsu_req_t req_i;
  logic      core_st_pending_i;
  logic      ld_req_valid_o, ld_req_ready_i;
  vlsu_req_t ld_req_o;
  logic      st_req_valid_o, st_req_ready_i;
  vlsu_req_t st_req_o;
  logic      ld_done_i, st_done_i;
  logic [1:0] ld_outstanding_o, st_outstanding_o;
  logic      idle_o;

  int checks = 0;
  int errors = 0;

  vlsu_req_dispatcher dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_i             (req_i),
    .core_st_pending_i (core_st_pending_i),
    .ld_req_valid_o    (ld_req_valid_o),
    .ld_req_ready_i    (ld_req_ready_i),
    .ld_req_o          (ld_req_o),
    .st_req_valid_o    (st_req_valid_o),
    .st_req_ready_i    (st_req_ready_i),
    .st_req_o          (st_req_o),
    .ld_done_i         (ld_done_i),
    .st_done_i         (st_done_i),
    .ld_outstanding_o  (ld_outstanding_o),
    .st_outstanding_o  (st_outstanding_o),
    .idle_o            (idle_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vlsu_req_t mk_req(input logic is_ld, input logic [7:0] rid);
    return '{isLoad: is_ld, id: rid, addr: {24'h0, rid}};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    req_valid_i = 1'b0; req_i = mk_req(1'b0, 8'h00);
    core_st_pending_i = 1'b0; ld_req_ready_i = 1'b0; st_req_ready_i = 1'b0;
    ld_done_i = 1'b0; st_done_i = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({ld_req_valid_o, st_req_valid_o} !== 2'b00) begin
      errors++; $display("FAIL reset_valids got %b want 00", {ld_req_valid_o, st_req_valid_o});
    end
    checks++;
    if ({ld_outstanding_o, st_outstanding_o} !== 4'h0) begin
      errors++; $display("FAIL reset_outstanding got %h want 0", {ld_outstanding_o, st_outstanding_o});
    end
    checks++;
    if (idle_o !== 1'b1 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_idle_ready got %b%b want 11", idle_o, req_ready_o);
    end
    tick();
  endtask

  // Three loads, done two cycles after each dispatch; third dispatch waits for the cap.
  task automatic test_back_to_back();
    logic [31:0] done_sched;
    int disp_cyc[3];
    int n_disp, peak;
    done_sched = '0; n_disp = 0; peak = 0;
    ld_req_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid_i = (c < 3);
      req_i = mk_req(1'b1, 8'(16 + c));
      ld_done_i = done_sched[c];
      #1;
      if (int'(ld_outstanding_o) > peak) peak = int'(ld_outstanding_o);
      if (ld_req_valid_o && ld_req_ready_i) begin
        checks++;
        if (ld_req_o.id !== 8'(16 + n_disp)) begin
          errors++; $display("FAIL b2b_order got %h want %h", ld_req_o.id, 8'(16 + n_disp));
        end
        if (n_disp < 3) disp_cyc[n_disp] = c;
        done_sched[c+2] = 1'b1;
        n_disp++;
      end
      tick();
    end
    quiet_inputs();
    #1;
    checks++;
    if (n_disp != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_disp); end
    checks++;
    if (disp_cyc[0] != 1 || disp_cyc[1] != 2 || disp_cyc[2] != 4) begin
      errors++; $display("FAIL b2b_cycles got %0d %0d %0d want 1 2 4", disp_cyc[0], disp_cyc[1], disp_cyc[2]);
    end
    checks++;
    if (peak != 2) begin errors++; $display("FAIL b2b_peak got %0d want 2", peak); end
    checks++;
    if (idle_o !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b want 1", idle_o); end
    tick();
  endtask

  // Older store holds a younger load until its done pulse.
  task automatic test_store_blocks_load();
    logic early;
    int ld_cyc;
    logic [7:0] ld_id;
    early = 1'b0; ld_cyc = -1; ld_id = 8'h00;
    ld_req_ready_i = 1'b1; st_req_ready_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      req_valid_i = (c < 2);
      req_i = (c == 0) ? mk_req(1'b0, 8'h20) : mk_req(1'b1, 8'h21);
      st_done_i = (c == 11);
      ld_done_i = (ld_cyc >= 0) && (c == ld_cyc + 2);
      #1;
      if (ld_req_valid_o && c <= 11) early = 1'b1;
      if (ld_req_valid_o && ld_cyc < 0) begin ld_cyc = c; ld_id = ld_req_o.id; end
      tick();
    end
    quiet_inputs();
    #1;
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL st_blk_early got %b want 0", early); end
    checks++;
    if (ld_cyc != 12) begin errors++; $display("FAIL st_blk_cycle got %0d want 12", ld_cyc); end
    checks++;
    if (ld_id !== 8'h21) begin errors++; $display("FAIL st_blk_id got %h want 21", ld_id); end
    checks++;
    if (idle_o !== 1'b1) begin errors++; $display("FAIL st_blk_idle got %b want 1", idle_o); end
    tick();
  endtask

  // Older load holds a younger store until ld_done_i.
  task automatic test_load_blocks_store();
    logic early;
    int st_cyc;
    early = 1'b0; st_cyc = -1;
    ld_req_ready_i = 1'b1; st_req_ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      req_valid_i = (c < 2);
      req_i = (c == 0) ? mk_req(1'b1, 8'h30) : mk_req(1'b0, 8'h31);
      ld_done_i = (c == 8);
      st_done_i = (st_cyc >= 0) && (c == st_cyc + 2);
      #1;
      if (st_req_valid_o && c <= 8) early = 1'b1;
      if (st_req_valid_o && st_cyc < 0) st_cyc = c;
      tick();
    end
    quiet_inputs();
    #1;
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL ld_blk_early got %b want 0", early); end
    checks++;
    if (st_cyc != 9) begin errors++; $display("FAIL ld_blk_cycle got %0d want 9", st_cyc); end
    checks++;
    if (idle_o !== 1'b1) begin errors++; $display("FAIL ld_blk_idle got %b want 1", idle_o); end
    tick();
  endtask

  task automatic test_core_st_pending();
    logic early;
    int ld_cyc;
    early = 1'b0; ld_cyc = -1;
    ld_req_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid_i = (c == 0);
      req_i = mk_req(1'b1, 8'h50);
      core_st_pending_i = (c < 5);
      ld_done_i = (c == 7);
      #1;
      if (ld_req_valid_o && c < 5) early = 1'b1;
      if (ld_req_valid_o && ld_cyc < 0) ld_cyc = c;
      tick();
    end
    quiet_inputs();
    #1;
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL pend_early got %b want 0", early); end
    checks++;
    if (ld_cyc != 5) begin errors++; $display("FAIL pend_cycle got %0d want 5", ld_cyc); end
    tick();
    // Spurious store done with nothing outstanding must not move any counter.
    st_done_i = 1'b1;
    tick();
    st_done_i = 1'b0;
    #1;
    checks++;
    if (st_outstanding_o !== 2'd0 || idle_o !== 1'b1) begin
      errors++; $display("FAIL spurious_out got %0d/%b want 0/1", st_outstanding_o, idle_o);
    end
    req_valid_i = 1'b1; req_i = mk_req(1'b1, 8'h51);
    tick();
    req_valid_i = 1'b0; ld_req_ready_i = 1'b1;
    #1;
    checks++;
    if (ld_req_valid_o !== 1'b1) begin
      errors++; $display("FAIL spurious_tag got %b want 1", ld_req_valid_o);
    end
    tick();
    ld_req_ready_i = 1'b0; ld_done_i = 1'b1;
    tick();
    ld_done_i = 1'b0;
    #1;
    checks++;
    if (idle_o !== 1'b1) begin errors++; $display("FAIL spurious_idle got %b want 1", idle_o); end
    tick();
  endtask

  // Leaves 4 loads and 1 blocked store queued for the mid-stream reset test.
  task automatic test_queue_full();
    int not_ready;
    not_ready = 0;
    ld_req_ready_i = 1'b0; st_req_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid_i = 1'b1; req_i = mk_req(1'b1, 8'(64 + c));
      #1;
      if (req_ready_o !== 1'b1) not_ready++;
      tick();
    end
    checks++;
    if (not_ready != 0) begin errors++; $display("FAIL full_fill got %0d stalls want 0", not_ready); end
    req_i = mk_req(1'b1, 8'h44);
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ld_ready got %b want 0", req_ready_o); end
    req_i = mk_req(1'b0, 8'h60);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL full_st_ready got %b want 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    #1;
    checks++;
    if (ld_req_valid_o !== 1'b1 || ld_req_o.id !== 8'h40) begin
      errors++; $display("FAIL full_head got %b/%h want 1/40", ld_req_valid_o, ld_req_o.id);
    end
    checks++;
    if (st_req_valid_o !== 1'b0) begin errors++; $display("FAIL full_st_blk got %b want 0", st_req_valid_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    ld_req_ready_i = 1'b1;
    #1;
    checks++;
    if (ld_req_o.id !== 8'h40) begin errors++; $display("FAIL mid_d0 got %h want 40", ld_req_o.id); end
    tick();
    checks++;
    if (ld_req_valid_o !== 1'b1 || ld_req_o.id !== 8'h41) begin
      errors++; $display("FAIL mid_d1 got %b/%h want 1/41", ld_req_valid_o, ld_req_o.id);
    end
    tick();
    ld_req_ready_i = 1'b0;
    #1;
    checks++;
    if (ld_outstanding_o !== 2'd2 || ld_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_cap got %0d/%b want 2/0", ld_outstanding_o, ld_req_valid_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({ld_req_valid_o, st_req_valid_o, idle_o, req_ready_o} !== 4'b0011) begin
      errors++; $display("FAIL mid_rst got %b want 0011", {ld_req_valid_o, st_req_valid_o, idle_o, req_ready_o});
    end
    checks++;
    if ({ld_outstanding_o, st_outstanding_o} !== 4'h0) begin
      errors++; $display("FAIL mid_rst_out got %h want 0", {ld_outstanding_o, st_outstanding_o});
    end
    req_valid_i = 1'b1; req_i = mk_req(1'b1, 8'h70);
    tick();
    req_valid_i = 1'b0;
    #1;
    checks++;
    if (ld_req_valid_o !== 1'b1 || ld_req_o.id !== 8'h70) begin
      errors++; $display("FAIL mid_after got %b/%h want 1/70", ld_req_valid_o, ld_req_o.id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store_blocks_load();
    test_load_blocks_store();
    test_core_st_pending();
    test_queue_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
